// File: rtl/vga_timing_pkg.sv
// Beam timing defaults shared with the sync generator, plus the read-owner encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY  = 640;
    localparam int VGA_H_TOTAL    = 800;
    localparam int VGA_V_DISPLAY  = 480;
    localparam int VGA_V_TOTAL    = 525;
    localparam int VGA_FETCH_LEAD = 8;
    localparam int BEAM_W         = 10;
    localparam int WAIT_W         = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/video_window_gen.sv
// Flags beam positions where the video fetch engine owns VRAM (active area plus fetch lead-in).
// Latency: 1 clock from hpos/vpos to vid_window.
// Backpressure: none; evaluated every cycle.
module video_window_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = VGA_H_DISPLAY,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_DISPLAY  = VGA_V_DISPLAY,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int FETCH_LEAD = VGA_FETCH_LEAD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BEAM_W-1:0] hpos,
    input  logic [BEAM_W-1:0] vpos,
    output logic              vid_window
);

    localparam logic [BEAM_W-1:0] H_DISP_B = BEAM_W'(H_DISPLAY);
    localparam logic [BEAM_W-1:0] H_TOT_B  = BEAM_W'(H_TOTAL);
    localparam logic [BEAM_W-1:0] H_OPEN_B = BEAM_W'(H_TOTAL - FETCH_LEAD);
    localparam logic [BEAM_W-1:0] V_DISP_B = BEAM_W'(V_DISPLAY);
    localparam logic [BEAM_W-1:0] V_PRE_B  = BEAM_W'(V_DISPLAY - 1);
    localparam logic [BEAM_W-1:0] V_LAST_B = BEAM_W'(V_TOTAL - 1);

    logic in_active;
    logic in_lead;

    // The lead-in opens only when the following line is visible: lines 0..V_DISPLAY-2
    // feed the next visible line, and the last frame line feeds line 0.
    always_comb begin
        in_active = (vpos < V_DISP_B) && (hpos < H_DISP_B);
        in_lead   = (hpos >= H_OPEN_B) && (hpos < H_TOT_B) &&
                    ((vpos < V_PRE_B) || (vpos == V_LAST_B));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vid_window <= 1'b0;
        end else begin
            vid_window <= in_active || in_lead;
        end
    end

endmodule

// File: rtl/vram_access_scheduler.sv
// Arbitrates single-port VRAM between the video fetch engine (strict priority) and a host port.
// Latency: grant same cycle, read data 1 clock after grant; 1 access per clock.
// Backpressure: host holds request until host_gnt; video is never stalled.
module vram_access_scheduler
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY       = VGA_H_DISPLAY,
    parameter int H_TOTAL         = VGA_H_TOTAL,
    parameter int V_DISPLAY       = VGA_V_DISPLAY,
    parameter int V_TOTAL         = VGA_V_TOTAL,
    parameter int FETCH_LEAD      = VGA_FETCH_LEAD,
    parameter int HOST_BLANK_ONLY = 1,
    parameter int ADDR_W          = 12,
    parameter int DATA_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BEAM_W-1:0] hpos,
    input  logic [BEAM_W-1:0] vpos,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vid_window,
    output logic [WAIT_W-1:0] host_wait_max
);

    localparam bit BLANK_GATE = (HOST_BLANK_ONLY != 0);
    localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

    owner_e            owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] frame_max;
    logic              frame_start;

    video_window_gen #(
        .H_DISPLAY  (H_DISPLAY),
        .H_TOTAL    (H_TOTAL),
        .V_DISPLAY  (V_DISPLAY),
        .V_TOTAL    (V_TOTAL),
        .FETCH_LEAD (FETCH_LEAD)
    ) u_window (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .vid_window (vid_window)
    );

    assign vid_gnt  = vid_req;
    assign host_gnt = host_req && !vid_req && (!BLANK_GATE || !vid_window);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (vid_gnt) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Reset clears the owner so a read in flight across reset never returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else if (vid_gnt) begin
            owner <= OWN_VID;
        end else if (host_gnt && !host_we) begin
            owner <= OWN_HOST;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign vid_rvalid  = (owner == OWN_VID);
    assign host_rvalid = (owner == OWN_HOST);
    assign vid_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

    assign frame_start = (hpos == '0) && (vpos == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            frame_max     <= '0;
            host_wait_max <= '0;
        end else begin
            if (!host_req || host_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (frame_start) begin
                host_wait_max <= frame_max;
                frame_max     <= '0;
            end else if (wait_cnt > frame_max) begin
                frame_max <= wait_cnt;
            end
        end
    end

endmodule
